jtpang_objdma: RTL and testbench

JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

---
 rtl/jtpang_pkg.sv | 17 +
 rtl/jtpang_objdma.sv | 118 +++++++++++
 tb/tb_jtpang_objdma.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpang_pkg.sv
// Object DMA shared definitions: state encodings and default geometry.
// Optional vblank gating is enabled with the JTPANG_DMA_VBWAIT_EN macro.
package jtpang_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_REQ   = 3'd2,
    ST_COPY  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_REL   = 3'd5
  } dma_st_e;

  localparam logic [11:0] DEF_SRC_BASE = 12'h000;
  localparam int          DEF_LEN      = 512;

endpackage

// File: rtl/jtpang_objdma.sv
// Object RAM DMA: takes the Z80 bus and copies LEN bytes into the obj buffer.
// Define JTPANG_DMA_VBWAIT_EN to hold the bus request until vertical blank.
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter logic [11:0] SRC_BASE = DEF_SRC_BASE,
  parameter int          LEN      = DEF_LEN
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        dma_go,
  input  logic        LVBL,
  input  logic        busak_n,
  output logic        busrq_n,
  output logic [11:0] src_addr,
  output logic        src_cs,
  input  logic [7:0]  src_dout,
  output logic [11:0] obj_addr,
  output logic [7:0]  obj_din,
  output logic        obj_we,
  output logic        busy
);

  localparam logic [11:0] LAST = 12'(LEN - 1);

  dma_st_e     st_q, st_d;
  logic        pend_q, pend_d;
  logic        go_q, go_d;
  logic [11:0] cnt_q, cnt_d;
  logic        wr_v_q, wr_v_d;
  logic [11:0] wr_a_q, wr_a_d;
  logic        start;
  logic        rise;

`ifdef JTPANG_DMA_VBWAIT_EN
  assign start = ~LVBL;
`else
  logic unused_lvbl;
  assign unused_lvbl = LVBL;
  assign start = 1'b1;
`endif

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    go_d   = go_q;
    cnt_d  = cnt_q;
    wr_v_d = wr_v_q;
    wr_a_d = wr_a_q;
    rise   = 1'b0;
    if (cen) begin
      go_d = dma_go;
      rise = dma_go & ~go_q;
      unique case (st_q)
        ST_IDLE: if (pend_q) st_d = ST_WAIT;
        ST_WAIT: if (start) begin
          st_d   = ST_REQ;
          pend_d = 1'b0;
        end
        ST_REQ: if (!busak_n) st_d = ST_COPY;
        ST_COPY: begin
          if (!busak_n) begin
            wr_v_d = 1'b1;
            wr_a_d = cnt_q;
            if (cnt_q == LAST) st_d = ST_DRAIN;
            else cnt_d = cnt_q + 12'd1;
          end else if (wr_v_q) begin
            // bus lost with a read in flight: re-read that byte later
            cnt_d  = wr_a_q;
            wr_v_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          wr_v_d = 1'b0;
          if (!busak_n) begin
            cnt_d = '0;
            st_d  = ST_REL;
          end else begin
            cnt_d = wr_a_q;
            st_d  = ST_COPY;
          end
        end
        ST_REL: if (busak_n) st_d = ST_IDLE;
        default: st_d = ST_IDLE;
      endcase
      if (rise) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      pend_q <= 1'b0;
      go_q   <= 1'b0;
      cnt_q  <= '0;
      wr_v_q <= 1'b0;
      wr_a_q <= '0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      go_q   <= go_d;
      cnt_q  <= cnt_d;
      wr_v_q <= wr_v_d;
      wr_a_q <= wr_a_d;
    end
  end

  assign busrq_n  = ~((st_q == ST_REQ) | (st_q == ST_COPY) |
                      (st_q == ST_DRAIN));
  assign src_addr = SRC_BASE + cnt_q;
  assign src_cs   = (st_q == ST_COPY) & ~busak_n;
  assign obj_we   = wr_v_q & ~busak_n;
  assign obj_addr = wr_a_q;
  assign obj_din  = obj_we ? src_dout : 8'h00;
  assign busy     = pend_q | (st_q != ST_IDLE);

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed scoreboard bench for jtpang_objdma.
// Build with JTPANG_DMA_VBWAIT_EN to exercise the vblank-gated variant.
module tb_jtpang_objdma;

  localparam int LEN = 4;
`ifdef JTPANG_DMA_VBWAIT_EN
  localparam logic [11:0] BASE = 12'hFFE;
`else
  localparam logic [11:0] BASE = 12'h100;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        dma_go = 1'b0;
  logic        LVBL = 1'b0;
  logic        busak_n;
  logic        busrq_n;
  logic [11:0] src_addr;
  logic        src_cs;
  logic [7:0]  src_dout = 8'h00;
  logic [11:0] obj_addr;
  logic [7:0]  obj_din;
  logic        obj_we;
  logic        busy;

  logic [7:0]  mem [4096];
  logic [19:0] q [$];
  logic [19:0] e_wr;
  int vec = 0;
  int bad = 0;
  int nwr = 0;
  int nreq = 0;
  int w0, r0;

  logic ack_n = 1'b1;
  logic hold_off = 1'b0;
  int   dly = 0;
  logic cen_div = 1'b0;
  logic smp_we = 1'b0;
  logic [11:0] smp_addr;
  logic [7:0]  smp_din;
  logic prev_rq = 1'b1;

  jtpang_objdma #(.SRC_BASE(BASE), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go),
    .LVBL(LVBL), .busak_n(busak_n), .busrq_n(busrq_n),
    .src_addr(src_addr), .src_cs(src_cs), .src_dout(src_dout),
    .obj_addr(obj_addr), .obj_din(obj_din), .obj_we(obj_we),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cen = cen_div ? ~cen : 1'b1;
  end

  always @(posedge clk) if (cen && src_cs) src_dout <= mem[src_addr];

  // Z80 grants the bus three cen cycles after the request
  always @(posedge clk) if (cen) begin
    if (!busrq_n) begin
      if (dly >= 3) ack_n <= 1'b0;
      else dly <= dly + 1;
    end else begin
      dly   <= 0;
      ack_n <= 1'b1;
    end
  end
  assign busak_n = ack_n | hold_off;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    smp_we   = cen && obj_we;
    smp_addr = obj_addr;
    smp_din  = obj_din;
    if (prev_rq && !busrq_n) nreq++;
    prev_rq = busrq_n;
  end

  always @(posedge clk) if (smp_we && rst_n) begin
    nwr++;
    chk("wr_queue", 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e_wr = q.pop_front();
      chk("wr_addr", {20'd0, smp_addr}, {20'd0, e_wr[19:8]});
      chk("wr_data", {24'd0, smp_din}, {24'd0, e_wr[7:0]});
    end
  end

  task automatic push_xfer();
    for (int k = 0; k < LEN; k++)
      q.push_back({BASE + 12'(k) - BASE, mem[BASE + 12'(k)]});
  endtask

  task automatic pulse_go(input int n);
    @(negedge clk);
    dma_go = 1'b1;
    repeat (n) @(negedge clk);
    dma_go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 0);
    chk({tag, "_left"}, q.size(), 0);
  endtask

  task automatic wait_rd(input logic [11:0] a, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(src_cs && src_addr == a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rd"}, {31'd0, src_cs}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[12'h100] = 8'hAA;
    mem[12'h101] = 8'hBB;
    mem[12'h102] = 8'hCC;
    mem[12'h103] = 8'hDD;
    mem[12'hFFE] = 8'h11;
    mem[12'hFFF] = 8'h22;
    mem[12'h000] = 8'h33;
    mem[12'h001] = 8'h44;

    repeat (3) @(negedge clk);
    chk("rst_busrq", {31'd0, busrq_n}, 1);
    chk("rst_cs", {31'd0, src_cs}, 0);
    chk("rst_we", {31'd0, obj_we}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_saddr", {20'd0, src_addr}, {20'd0, BASE});
    chk("rst_oaddr", {20'd0, obj_addr}, 0);
    chk("rst_din", {24'd0, obj_din}, 0);
    rst_n = 1'b1;

    // single short strobe
    w0 = nwr; r0 = nreq;
    push_xfer();
    pulse_go(1);
    wait_idle("t1");
    chk("t1_busrq", {31'd0, busrq_n}, 1);
    chk("t1_nwr", nwr - w0, LEN);
    chk("t1_nreq", nreq - r0, 1);

    // held level must not retrigger
    w0 = nwr; r0 = nreq;
    push_xfer();
    pulse_go(10);
    wait_idle("t2");
    chk("t2_nwr", nwr - w0, LEN);
    chk("t2_nreq", nreq - r0, 1);

    // two edges during COPY merge into one extra transfer
    w0 = nwr; r0 = nreq;
    push_xfer();
    push_xfer();
    pulse_go(1);
    wait_rd(BASE, "t3");
    dma_go = 1'b1;
    @(negedge clk);
    dma_go = 1'b0;
    @(negedge clk);
    dma_go = 1'b1;
    @(negedge clk);
    dma_go = 1'b0;
    wait_idle("t3");
    chk("t3_nwr", nwr - w0, 2 * LEN);
    chk("t3_nreq", nreq - r0, 2);

    // bus taken away mid-copy for five cycles
    w0 = nwr;
    push_xfer();
    pulse_go(1);
    wait_rd(BASE + 12'd1, "t4");
    @(posedge clk);
    #1 hold_off = 1'b1;
    #1;
    chk("t4_frz_cs", {31'd0, src_cs}, 0);
    chk("t4_frz_we", {31'd0, obj_we}, 0);
    repeat (5) @(posedge clk);
    #1 hold_off = 1'b0;
    wait_idle("t4");
    chk("t4_nwr", nwr - w0, LEN);

    // half-rate clock enable
    cen_div = 1'b1;
    w0 = nwr;
    push_xfer();
    pulse_go(2);
    wait_idle("t5");
    chk("t5_nwr", nwr - w0, LEN);
    cen_div = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-transfer abandons it
    w0 = nwr; r0 = nreq;
    pulse_go(1);
    wait_rd(BASE, "t6");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busrq", {31'd0, busrq_n}, 1);
    chk("t6_we", {31'd0, obj_we}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_nwr", nwr - w0, 0);
    chk("t6_nreq", nreq - r0, 1);
    chk("t6_idle", {31'd0, busy}, 0);

`ifdef JTPANG_DMA_VBWAIT_EN
    // request held off until blank, then runs through LVBL rising
    LVBL = 1'b1;
    w0 = nwr; r0 = nreq;
    push_xfer();
    pulse_go(1);
    repeat (20) @(negedge clk);
    chk("t7_hold_rq", {31'd0, busrq_n}, 1);
    chk("t7_hold_n", nreq - r0, 0);
    chk("t7_hold_busy", {31'd0, busy}, 1);
    LVBL = 1'b0;
    wait_rd(BASE, "t7");
    LVBL = 1'b1;
    wait_idle("t7");
    chk("t7_nwr", nwr - w0, LEN);
    LVBL = 1'b0;
`else
    // LVBL has no effect in this build
    LVBL = 1'b1;
    w0 = nwr;
    push_xfer();
    pulse_go(1);
    wait_idle("t7");
    chk("t7_nwr", nwr - w0, LEN);
    LVBL = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
